// File: rtl/program_mem_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : program_mem_controller_if
// Description : Program-memory read bus bundle. Carries both the per-fetcher
//               valid/ready read channel and the single external memory read
//               channel. The controller takes the slave view; the fetchers
//               and memory together form the master view.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_mem_controller_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
);

  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;

  // Fetchers plus program memory: issue requests, return memory words
  modport master (
    output consumer_read_valid,
    output consumer_read_address,
    input  consumer_read_ready,
    input  consumer_read_data,
    input  mem_read_valid,
    input  mem_read_address,
    output mem_read_ready,
    output mem_read_data
  );

  // Controller: responds to fetchers, drives the memory request
  modport slave (
    input  consumer_read_valid,
    input  consumer_read_address,
    output consumer_read_ready,
    output consumer_read_data,
    output mem_read_valid,
    output mem_read_address,
    input  mem_read_ready,
    input  mem_read_data
  );

endinterface
`default_nettype wire

// File: rtl/program_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : program_mem_controller
// Description : Round-robin arbiter that funnels read requests from several
//               fetch units onto one program-memory read channel and returns
//               each word to its requester with a one-cycle ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module program_mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  program_mem_controller_if.slave bus
);

  // Pointer width is kept at least one bit so a single-consumer build still
  // has a legal (constant zero) pointer.
  localparam int c_ptr_bits = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [c_ptr_bits-1:0] c_last_idx = c_ptr_bits'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESPOND  = 2'd2
  } state_t;

  state_t                   r_state;
  logic [c_ptr_bits-1:0]    r_rr_ptr;
  logic [c_ptr_bits-1:0]    r_grant;
  logic [NUM_CONSUMERS-1:0] r_armed;
  logic [NUM_CONSUMERS-1:0] r_ready;
  logic [DATA_BITS-1:0]     r_data [NUM_CONSUMERS];
  logic                     r_mem_valid;
  logic [ADDR_BITS-1:0]     r_mem_addr;

  logic [NUM_CONSUMERS-1:0]           w_eligible;
  logic                               w_found;
  logic [c_ptr_bits-1:0]              w_pick;
  logic [c_ptr_bits-1:0]              w_next_ptr;
  logic [ADDR_BITS-1:0]               w_addr [NUM_CONSUMERS];
  logic [NUM_CONSUMERS*DATA_BITS-1:0] w_data_flat;

  // A consumer may only win while its valid is up and it has been re-armed
  // by a sampled low valid since its last response.
  assign w_eligible = bus.consumer_read_valid & r_armed;

  // Split the flattened address bus into per-consumer words
  always_comb begin
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      w_addr[i] = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Round-robin search starting at rr_ptr; scanning offsets from the far end
  // down lets the smallest offset win by being assigned last.
  always_comb begin
    int                    v_idx;
    logic [c_ptr_bits-1:0] v_sel;
    v_idx   = 0;
    v_sel   = '0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NUM_CONSUMERS) begin
        v_idx = v_idx - NUM_CONSUMERS;
      end
      v_sel = c_ptr_bits'(v_idx);
      if (w_eligible[v_sel]) begin
        w_found = 1'b1;
        w_pick  = v_sel;
      end
    end
  end

  // Pointer advances past the winner, wrapping explicitly so non-power-of-two
  // consumer counts never land on an unused index.
  always_comb begin
    w_next_ptr = (w_pick == c_last_idx) ? '0 : w_pick + 1'b1;
  end

  // Flatten per-consumer response words onto the output bus
  always_comb begin
    w_data_flat = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      w_data_flat[i*DATA_BITS +: DATA_BITS] = r_data[i];
    end
  end

  assign bus.consumer_read_ready = r_ready;
  assign bus.consumer_read_data  = w_data_flat;
  assign bus.mem_read_valid      = r_mem_valid;
  assign bus.mem_read_address    = r_mem_addr;

  // Arbitration / memory handshake FSM with registered outputs and arm flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_armed     <= '1;
      r_ready     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant     <= w_pick;
            r_mem_valid <= 1'b1;
            r_mem_addr  <= w_addr[w_pick];
            r_rr_ptr    <= w_next_ptr;
            r_state     <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          // Request is held stable until memory answers, however long it takes
          if (bus.mem_read_ready) begin
            r_data[r_grant]  <= bus.mem_read_data;
            r_ready[r_grant] <= 1'b1;
            r_armed[r_grant] <= 1'b0;
            r_mem_valid      <= 1'b0;
            r_state          <= RESPOND;
          end
        end
        RESPOND: begin
          r_ready <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_ready     <= '0;
          r_mem_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
      // A sampled low valid re-arms the consumer; placed after the FSM so a
      // consumer that dropped valid mid-transaction is re-armed at once.
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        if (!bus.consumer_read_valid[i]) begin
          r_armed[i] <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_mem_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_mem_controller
// Description : Scoreboard bench for program_mem_controller. Stimulus pushes
//               expected (consumer, word) responses; a monitor pops and
//               compares on every consumer ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_mem_controller;

  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 16;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          failures  = 0;
  int          mem_stall = 0;
  bit          mem_auto  = 1'b1;
  bit          mem_force = 1'b0;
  bit          ovr_en    = 1'b0;
  logic [15:0] ovr_data  = 16'h0;
  int          mem_reads = 0;

  always #5 clk = ~clk;

  program_mem_controller_if #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  program_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic logic [DB-1:0] slot(input int i);
    return bus.consumer_read_data[i*DB +: DB];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_resp(input int i, input logic [15:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic set_addr(input int i, input logic [AB-1:0] a);
    bus.consumer_read_address[i*AB +: AB] = a;
  endtask

  // Fetcher behaviour: raise valid, keep it high for the cycle after ready,
  // then drop it for good.
  task automatic fetch(input logic [N-1:0] mask);
    int hold [N];
    int remaining;
    remaining = 0;
    for (int i = 0; i < N; i++) begin
      hold[i] = -2;
      if (mask[i]) begin
        hold[i] = -1;
        bus.consumer_read_valid[i] = 1'b1;
        remaining++;
      end
    end
    for (int c = 0; c < 200 && remaining > 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (hold[i] > 0) begin
          hold[i]--;
          if (hold[i] == 0) begin
            bus.consumer_read_valid[i] = 1'b0;
            hold[i] = -2;
            remaining--;
          end
        end else if (hold[i] == -1 && bus.consumer_read_ready[i]) begin
          hold[i] = 2;
        end
      end
    end
    check("fetch_complete_remaining", 64'(remaining), 64'd0);
  endtask

  // Memory model: answers after mem_stall cycles with 0x1000+addr or an override
  initial begin
    int  cnt;
    bit  prev_v;
    cnt    = 0;
    prev_v = 1'b0;
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_valid && !prev_v) mem_reads++;
      prev_v = bus.mem_read_valid;
      if (!mem_auto) begin
        bus.mem_read_ready = mem_force;
        cnt = 0;
      end else if (bus.mem_read_ready) begin
        bus.mem_read_ready = 1'b0;
      end else if (bus.mem_read_valid) begin
        if (cnt < mem_stall) begin
          cnt++;
        end else begin
          cnt = 0;
          bus.mem_read_ready = 1'b1;
          bus.mem_read_data  = ovr_en ? ovr_data : (16'h1000 + 16'(bus.mem_read_address));
        end
      end
    end
  end

  // Monitor: every ready pulse must match the head of the scoreboard
  initial begin
    int   got;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.consumer_read_ready != '0) begin
        got = 0;
        for (int i = 0; i < N; i++) if (bus.consumer_read_ready[i]) got = i;
        check("ready_onehot", 64'($onehot(bus.consumer_read_ready)), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: consumer %0d pulsed, none expected", got);
        end else begin
          e = exp_q.pop_front();
          check("resp_consumer", 64'(got), 64'(e.idx));
          check("resp_data", 64'(slot(got)), 64'(e.data));
        end
      end
    end
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    int bad;
    int r0;
    reset = 1'b1;
    bus.consumer_read_valid   = '0;
    bus.consumer_read_address = '0;
    #1;
    check("reset_mem_valid", 64'(bus.mem_read_valid), 64'd0);
    check("reset_mem_addr", 64'(bus.mem_read_address), 64'd0);
    check("reset_ready", 64'(bus.consumer_read_ready), 64'd0);
    check("reset_data", 64'(bus.consumer_read_data), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single request: consumer 1, addr 0x2A, word 0xBEEF, no stall
    ovr_en = 1'b1; ovr_data = 16'hBEEF; mem_stall = 0;
    set_addr(1, 8'h2A);
    bus.consumer_read_valid[1] = 1'b1;
    expect_resp(1, 16'hBEEF);
    @(negedge clk);
    check("t1_mem_valid", 64'(bus.mem_read_valid), 64'd1);
    check("t1_mem_addr", 64'(bus.mem_read_address), 64'h2A);
    check("t1_ready_c1", 64'(bus.consumer_read_ready), 64'd0);
    @(negedge clk);
    check("t1_ready_c2", 64'(bus.consumer_read_ready), 64'b0010);
    @(negedge clk);
    check("t1_ready_c3", 64'(bus.consumer_read_ready), 64'd0);
    @(negedge clk);
    bus.consumer_read_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_data_held", 64'(slot(1)), 64'hBEEF);
    check("t1_one_read", 64'(mem_reads), 64'd1);

    // Memory stall of 5 cycles: request must stay stable throughout
    ovr_en = 1'b0; mem_stall = 5;
    set_addr(2, 8'h55);
    bus.consumer_read_valid[2] = 1'b1;
    expect_resp(2, 16'h1055);
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (!(bus.mem_read_valid === 1'b1 && bus.mem_read_address === 8'h55 &&
            bus.consumer_read_ready === 4'b0)) bad++;
    end
    check("t2_stable_cycles_bad", 64'(bad), 64'd0);
    @(negedge clk);
    check("t2_ready_pulse", 64'(bus.consumer_read_ready), 64'b0100);
    @(negedge clk);
    check("t2_ready_cleared", 64'(bus.consumer_read_ready), 64'd0);
    @(negedge clk);
    bus.consumer_read_valid[2] = 1'b0;
    mem_stall = 0;
    repeat (2) @(negedge clk);

    // Consumer 3 alone brings rr_ptr back to 0
    set_addr(3, 8'h33);
    expect_resp(3, 16'h1033);
    fetch(4'b1000);
    repeat (2) @(negedge clk);

    // Contention: all four at once -> 0,1,2,3
    for (int i = 0; i < N; i++) set_addr(i, 8'(8'h10 + i));
    for (int i = 0; i < N; i++) expect_resp(i, 16'(16'h1010 + i));
    fetch(4'b1111);
    repeat (2) @(negedge clk);
    // Consumers 0 and 2 with rr_ptr=0 -> 0,2
    expect_resp(0, 16'h1010);
    expect_resp(2, 16'h1012);
    fetch(4'b0101);
    repeat (2) @(negedge clk);
    // Consumers 1 and 3 with rr_ptr=3 -> 3 first, then 1
    expect_resp(3, 16'h1013);
    expect_resp(1, 16'h1011);
    fetch(4'b1010);
    repeat (2) @(negedge clk);

    // Re-arm: valid held one cycle past ready causes no second read
    r0 = mem_reads;
    set_addr(0, 8'h20);
    expect_resp(0, 16'h1020);
    fetch(4'b0001);
    repeat (4) @(negedge clk);
    check("t4_single_read", 64'(mem_reads - r0), 64'd1);
    set_addr(0, 8'h21);
    expect_resp(0, 16'h1021);
    fetch(4'b0001);
    repeat (2) @(negedge clk);
    check("t4_reraise_read", 64'(mem_reads - r0), 64'd2);

    // Reset while in MEM_WAIT, then a stale memory response
    mem_auto = 1'b0;
    set_addr(1, 8'h77);
    bus.consumer_read_valid[1] = 1'b1;
    @(negedge clk);
    check("t5_mem_valid_before", 64'(bus.mem_read_valid), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_mem_valid_reset", 64'(bus.mem_read_valid), 64'd0);
    check("t5_mem_addr_reset", 64'(bus.mem_read_address), 64'd0);
    check("t5_ready_reset", 64'(bus.consumer_read_ready), 64'd0);
    check("t5_data_reset", 64'(bus.consumer_read_data), 64'd0);
    bus.consumer_read_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 mem_force = 1'b1;
    @(negedge clk);
    #1 mem_force = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_mem_valid_after", 64'(bus.mem_read_valid), 64'd0);
    mem_auto = 1'b1;
    // rr_ptr must be 0 again: 1 and 3 together -> 1 first
    set_addr(1, 8'h41);
    set_addr(3, 8'h43);
    expect_resp(1, 16'h1041);
    expect_resp(3, 16'h1043);
    fetch(4'b1010);
    repeat (2) @(negedge clk);

    // Data isolation between slots 0 and 3
    ovr_en = 1'b1; ovr_data = 16'h1111;
    set_addr(0, 8'h01);
    expect_resp(0, 16'h1111);
    fetch(4'b0001);
    repeat (2) @(negedge clk);
    ovr_data = 16'h3333;
    set_addr(3, 8'h03);
    expect_resp(3, 16'h3333);
    fetch(4'b1000);
    repeat (2) @(negedge clk);
    check("t6_slot0_kept", 64'(slot(0)), 64'h1111);
    check("t6_slot3_new", 64'(slot(3)), 64'h3333);
    check("t6_slot1_kept", 64'(slot(1)), 64'h1041);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_mem_controller.md
# program_mem_controller

Responder side of the program-memory valid/ready read protocol used by the per-core fetch units. It accepts read requests from NUM_CONSUMERS fetchers and arbitrates them round-robin onto a single external program-memory read channel. It returns each instruction word to the requesting fetcher with a one-cycle ready pulse. It sits between the cores' fetch units and the program memory.

## Interface
- NUM_CONSUMERS, 4: number of fetch requesters (≥1)
- ADDR_BITS, 8: program memory address width
- DATA_BITS, 16: instruction word width
- clk  input  1  clock, all logic on rising edge
- reset  input  1  reset, asynchronous, active-high
- consumer_read_valid  input  NUM_CONSUMERS  per-consumer read request
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened addresses; consumer i at [i*ADDR_BITS +: ADDR_BITS]
- consumer_read_ready  output  NUM_CONSUMERS  per-consumer response pulse, registered
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flattened per-consumer returned words, registered
- mem_read_valid  output  1  request to program memory, registered
- mem_read_address  output  ADDR_BITS  address to program memory, registered
- mem_read_ready  input  1  program memory response valid
- mem_read_data  input  DATA_BITS  program memory word, sampled when mem_read_ready=1

## Operation
- Reset values:
  - all outputs 0
  - state IDLE
  - rr_ptr 0
  - armed[] all 1
  - grant index 0
- armed[i]:
  - consumer i is eligible only when consumer_read_valid[i]=1 and armed[i]=1.
  - armed[i] clears on the edge that raises consumer_read_ready[i].
  - armed[i] sets on any edge where consumer_read_valid[i]=0 is sampled.
  - This rejects the fetcher's valid, which stays high for one cycle after ready.
- State IDLE:
  - If any consumer is eligible, pick the lowest index i at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
  - Register grant=i, mem_read_valid<=1, mem_read_address<=consumer i's address.
  - Set rr_ptr <= (i+1) mod NUM_CONSUMERS and go to MEM_WAIT.
  - With no eligible consumer, stay in IDLE.
- State MEM_WAIT:
  - mem_read_valid and mem_read_address are held stable.
  - When mem_read_ready=1 is sampled:
    - consumer_read_data[grant] <= mem_read_data
    - consumer_read_ready[grant] <= 1
    - mem_read_valid <= 0
    - go to RESPOND
  - No timeout; the controller waits indefinitely.
- State RESPOND:
  - consumer_read_ready[grant] is 1 for this cycle only; it is cleared on the exiting edge.
  - Go to IDLE.
- mem_read_ready is ignored outside MEM_WAIT.
- consumer_read_data[i] holds its value until the next response to consumer i. Other consumers' data slots are never disturbed.
- Address is sampled once, at grant. Later changes to consumer_read_address while in MEM_WAIT have no effect.
- Consumer drops valid mid-transaction (protocol violation): the memory read still completes and the ready pulse is still issued. armed[i] then re-sets from the low valid.
- Reset mid-operation (any state): return to reset values immediately, i.e. asynchronously. mem_read_valid drops and no ready pulse is issued. Any in-flight memory response after reset is ignored.
- At most one consumer_read_ready bit is high in any cycle.
- The rr_ptr update uses modulo arithmetic on $clog2(NUM_CONSUMERS) bits, with an explicit wrap when NUM_CONSUMERS is not a power of two. With NUM_CONSUMERS=1, rr_ptr stays at 0.

## Timing
- Cycle 0: eligible valid sampled in IDLE.
- Cycle 1: mem_read_valid=1 with the address.
- Cycle 1+k: memory asserts mem_read_ready, k≥0 stall cycles.
- Cycle 2+k: consumer_read_ready[i]=1 and data valid in the same cycle.
- Cycle 3+k: back in IDLE, able to arbitrate.
- Minimum latency from valid sampled to ready: 2 cycles.
- Minimum spacing between grants: 3 cycles.
- The fetcher samples ready and data together, because both are registered on the same edge.
- If a fetcher's valid is high again in the cycle after ready, it is not re-granted. It needs one sampled low cycle first.

## Test plan
- Single request, consumer 1, addr 0x2A, memory ready the cycle after mem_read_valid with data 0xBEEF:
  - mem_read_address=0x2A in cycle 1
  - consumer_read_ready[1] pulses exactly one cycle in cycle 2
  - consumer_read_data[1]=0xBEEF, held afterwards
- Memory stall: mem_read_ready delayed 5 cycles → mem_read_valid and address stay constant for all 5 cycles, the ready pulse comes 1 cycle after mem_read_ready, and there are no spurious pulses.
- Contention: all 4 consumers request addresses 0x10-0x13 simultaneously and re-request after each response. Grants must follow:
  - first round: 0,1,2,3
  - then request only from 0 and 2 with rr_ptr=0 → order 0,2
  - each consumer receives its own word, 0x1000+addr
- Re-arm: the fetcher holds valid high one cycle after ready, then drops it → no second memory read. A later re-raise of valid yields a new read.
- Reset in MEM_WAIT: assert reset while mem_read_valid=1, then deliver mem_read_ready after release → all outputs 0 during reset, no consumer_read_ready pulse, state IDLE, rr_ptr=0.
- Data isolation: after consumer 0 receives 0x1111, consumer 3 receives 0x3333 → consumer_read_data slot 0 still reads 0x1111.
